// File: rtl/des_region_scheduler_pkg.sv
// Shared types and widths for the region scheduler and its lanes.
package des_region_scheduler_pkg;

  localparam int unsigned COUNTER_W = 48;
  localparam int unsigned REGION_W  = 16;
  localparam int unsigned COUNT_W   = 17;
  localparam int unsigned TOTAL_W   = 64;

  typedef enum logic [1:0] {
    LaneIdle,
    LaneRun,
    LaneHold,
    LaneGap
  } lane_state_e;

  typedef enum logic [1:0] {
    TopIdle,
    TopRun,
    TopDrain
  } top_state_e;

  // Zero-extend a lane counter into the accumulator width.
  function automatic logic [TOTAL_W-1:0] widen_counter(input logic [COUNTER_W-1:0] c);
    return {{(TOTAL_W - COUNTER_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/des_region_scheduler_if.sv
// Scheduler <-> des_block array bus: per-lane start/region out, counter/valid back.
interface des_region_scheduler_if
  import des_region_scheduler_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 4
) ();

  logic [NUM_BLOCKS-1:0]           blk_start;
  logic [REGION_W*NUM_BLOCKS-1:0]  blk_region;
  logic [COUNTER_W*NUM_BLOCKS-1:0] blk_counter;
  logic [NUM_BLOCKS-1:0]           blk_valid;

  modport master (
    output blk_start,
    output blk_region,
    input  blk_counter,
    input  blk_valid
  );

  modport slave (
    input  blk_start,
    input  blk_region,
    output blk_counter,
    output blk_valid
  );

endinterface

// File: rtl/des_region_scheduler_lane.sv
// One des_block lane: IDLE -> RUN -> HOLD -> GAP -> IDLE, with counter capture.
module des_region_scheduler_lane
  import des_region_scheduler_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  input  logic                 kill,
  input  logic                 grant,
  input  logic [REGION_W-1:0]  region_in,
  input  logic                 valid,
  input  logic [COUNTER_W-1:0] counter,
  output lane_state_e          state,
  output logic                 blk_start,
  output logic [REGION_W-1:0]  blk_region,
  output logic [COUNTER_W-1:0] captured
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);

  lane_state_e          state_q, state_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [REGION_W-1:0]  region_q, region_d;
  logic [COUNTER_W-1:0] cap_q, cap_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LaneIdle;
      gap_q    <= '0;
      region_q <= '0;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      region_q <= region_d;
      cap_q    <= cap_d;
    end
  end

  // Next-state: abort beats a same-cycle valid, so a killed run never accumulates.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    region_d = region_q;
    cap_d    = cap_q;
    unique case (state_q)
      LaneIdle: begin
        if (issue) begin
          state_d  = LaneRun;
          region_d = region_in;
        end
      end
      LaneRun: begin
        if (kill) begin
          state_d = LaneGap;
          gap_d   = GapLoad;
        end else if (valid) begin
          state_d = LaneHold;
          cap_d   = counter;
        end
      end
      LaneHold: begin
        if (grant) begin
          state_d = LaneGap;
          gap_d   = GapLoad;
        end
      end
      LaneGap: begin
        if (gap_q == '0) begin
          state_d = LaneIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = LaneIdle;
    endcase
  end

  // Outputs: start stays high through HOLD so des_block keeps its counter stable.
  always_comb begin
    state      = state_q;
    blk_start  = (state_q == LaneRun) || (state_q == LaneHold);
    blk_region = region_q;
    captured   = cap_q;
  end

endmodule

// File: rtl/des_region_scheduler.sv
// Hands regions to des_block lanes, collects their counters and sums them.
module des_region_scheduler
  import des_region_scheduler_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [REGION_W-1:0]    region_first,
  input  logic [COUNT_W-1:0]     region_count,
  des_region_scheduler_if.master blk,
  output logic [TOTAL_W-1:0]     total,
  output logic [COUNT_W-1:0]     regions_done,
  output logic                   busy,
  output logic                   done
);

  top_state_e           top_q, top_d;
  logic [REGION_W-1:0]  next_region_q, next_region_d;
  logic [COUNT_W-1:0]   remaining_q, remaining_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [COUNT_W-1:0]   regions_done_q, regions_done_d;
  logic                 done_q, done_d;

  lane_state_e          lane_state [NUM_BLOCKS];
  logic [COUNTER_W-1:0] lane_cap [NUM_BLOCKS];
  logic [REGION_W-1:0]  lane_region [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] lane_start;
  logic [NUM_BLOCKS-1:0] lane_idle;
  logic [NUM_BLOCKS-1:0] issue_vec;
  logic [NUM_BLOCKS-1:0] grant_vec;
  logic                 issue_en;
  logic                 issue_any;
  logic                 grant_any;
  logic [COUNTER_W-1:0] acc_value;
  logic                 all_idle;
  logic                 accept;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_lane
    des_region_scheduler_lane #(
      .GAP_CYCLES(GAP_CYCLES)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .issue     (issue_vec[i]),
      .kill      (abort),
      .grant     (grant_vec[i]),
      .region_in (next_region_q),
      .valid     (blk.blk_valid[i]),
      .counter   (blk.blk_counter[COUNTER_W*i +: COUNTER_W]),
      .state     (lane_state[i]),
      .blk_start (lane_start[i]),
      .blk_region(lane_region[i]),
      .captured  (lane_cap[i])
    );
  end

  // Fixed-priority issue and accumulate arbiters; lowest lane index wins both.
  always_comb begin
    issue_vec = '0;
    grant_vec = '0;
    issue_any = 1'b0;
    grant_any = 1'b0;
    acc_value = '0;
    lane_idle = '0;
    issue_en  = (top_q == TopRun) && (remaining_q != '0) && !abort;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      lane_idle[i] = (lane_state[i] == LaneIdle);
      if (issue_en && lane_idle[i] && !issue_any) begin
        issue_vec[i] = 1'b1;
        issue_any    = 1'b1;
      end
      if ((lane_state[i] == LaneHold) && !grant_any) begin
        grant_vec[i] = 1'b1;
        grant_any    = 1'b1;
        acc_value    = lane_cap[i];
      end
    end
    all_idle = &lane_idle;
  end

  // Top state and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q          <= TopIdle;
      next_region_q  <= '0;
      remaining_q    <= '0;
      total_q        <= '0;
      regions_done_q <= '0;
      done_q         <= 1'b0;
    end else begin
      top_q          <= top_d;
      next_region_q  <= next_region_d;
      remaining_q    <= remaining_d;
      total_q        <= total_d;
      regions_done_q <= regions_done_d;
      done_q         <= done_d;
    end
  end

  // Top next-state; an empty job goes straight to DRAIN so busy lasts a single cycle.
  always_comb begin
    accept = (top_q == TopIdle) && start;
    top_d  = top_q;
    unique case (top_q)
      TopIdle: begin
        if (start) top_d = (region_count == '0) ? TopDrain : TopRun;
      end
      TopRun: begin
        if (abort || (remaining_q == '0)) top_d = TopDrain;
      end
      TopDrain: begin
        if (all_idle) top_d = TopIdle;
      end
      default: top_d = TopIdle;
    endcase
  end

  // Issue pointer, remaining count and accumulator updates.
  always_comb begin
    next_region_d  = next_region_q;
    remaining_d    = remaining_q;
    total_d        = total_q;
    regions_done_d = regions_done_q;
    if (accept) begin
      next_region_d  = region_first;
      remaining_d    = region_count;
      total_d        = '0;
      regions_done_d = '0;
    end else begin
      if (issue_any) begin
        next_region_d = next_region_q + 16'd1;
        remaining_d   = remaining_q - 17'd1;
      end
      if (grant_any) begin
        total_d        = total_q + widen_counter(acc_value);
        regions_done_d = regions_done_q + 17'd1;
      end
    end
    done_d = (top_q == TopDrain) && (top_d == TopIdle);
  end

  // Outputs and lane bus packing.
  always_comb begin
    busy           = (top_q != TopIdle);
    done           = done_q;
    total          = total_q;
    regions_done   = regions_done_q;
    blk.blk_start  = lane_start;
    blk.blk_region = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      blk.blk_region[REGION_W*i +: REGION_W] = lane_region[i];
    end
  end

  // Each arbiter picks at most one lane, and issue and grant never share a lane.
  a_arb_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(issue_vec) && $onehot0(grant_vec) && ((issue_vec & grant_vec) == '0));

endmodule

// File: tb/tb_des_region_scheduler.sv
// Directed bench for des_region_scheduler with a behavioural des_block model per lane.
module tb_des_region_scheduler;
  import des_region_scheduler_pkg::*;

  localparam int unsigned NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] region_first;
  logic [16:0] region_count;
  logic [63:0] total;
  logic [16:0] regions_done;
  logic        busy;
  logic        done;

  des_region_scheduler_if #(.NUM_BLOCKS(NB)) bif ();

  des_region_scheduler #(
    .NUM_BLOCKS(NB),
    .GAP_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .region_first(region_first),
    .region_count(region_count),
    .blk         (bif.master),
    .total       (total),
    .regions_done(regions_done),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // des_block model state and monitors
  int           lat_cfg [NB];
  int           mcnt [NB];
  logic [NB-1:0] prev_start = '0;
  logic [15:0]  issue_log [$];
  int           acc_cyc [$];
  logic [63:0]  acc_delta [$];
  int           done_cnt = 0;
  int           start_seen = 0;
  int           cyc = 0;
  logic [16:0]  prev_rd = '0;
  logic [63:0]  prev_total = '0;

  initial begin
    bif.blk_valid   = '0;
    bif.blk_counter = '0;
    for (int i = 0; i < int'(NB); i++) mcnt[i] = 0;
  end

  // Model: valid rises lat_cfg cycles after start rises, counter = region*3+1.
  always @(negedge clk) begin
    logic [47:0] v;
    cyc++;
    for (int i = 0; i < int'(NB); i++) begin
      if (bif.blk_start[i] && !prev_start[i]) issue_log.push_back(bif.blk_region[16*i +: 16]);
      if (bif.blk_start[i]) start_seen++;
      if (!bif.blk_start[i]) begin
        mcnt[i]          = 0;
        bif.blk_valid[i] = 1'b0;
        bif.blk_counter[48*i +: 48] = '0;
      end else begin
        mcnt[i]++;
        if (mcnt[i] >= lat_cfg[i]) begin
          v = 48'(bif.blk_region[16*i +: 16]) * 48'd3 + 48'd1;
          bif.blk_valid[i] = 1'b1;
          bif.blk_counter[48*i +: 48] = v;
        end
      end
    end
    prev_start = bif.blk_start;
    if (done) done_cnt++;
    if (regions_done == prev_rd + 17'd1) begin
      acc_cyc.push_back(cyc);
      acc_delta.push_back(total - prev_total);
    end
    prev_rd    = regions_done;
    prev_total = total;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_cfg[0] = l0;
    lat_cfg[1] = l1;
    lat_cfg[2] = l2;
    lat_cfg[3] = l3;
  endtask

  task automatic clear_logs();
    issue_log.delete();
    acc_cyc.delete();
    acc_delta.delete();
    done_cnt   = 0;
    start_seen = 0;
  endtask

  task automatic pulse_start(input logic [15:0] first, input logic [16:0] count);
    step();
    region_first = first;
    region_count = count;
    start        = 1'b1;
    step();
    start = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({name, "_timeout"}, 64'(ok), 64'd1);
    repeat (3) step();
  endtask

  typedef struct {
    logic [15:0] first;
    logic [16:0] count;
    int          lat;
    logic [63:0] exp_total;
    logic [16:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [15:0] exp_r;
    vecs[0] = '{first: 16'd5,      count: 17'd1,  lat: 10, exp_total: 64'd16,     exp_rd: 17'd1};
    vecs[1] = '{first: 16'd0,      count: 17'd10, lat: 10, exp_total: 64'd145,    exp_rd: 17'd10};
    vecs[2] = '{first: 16'hFFFE,   count: 17'd4,  lat: 10, exp_total: 64'd393214, exp_rd: 17'd4};
    vecs[3] = '{first: 16'd100,    count: 17'd7,  lat: 6,  exp_total: 64'd2170,   exp_rd: 17'd7};
    vecs[4] = '{first: 16'd7,      count: 17'd9,  lat: 3,  exp_total: 64'd306,    exp_rd: 17'd9};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    region_first = '0;
    region_count = '0;
    set_lat(10, 10, 10, 10);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_total", total, 64'd0);
    check("rst_regions_done", 64'(regions_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_blk_start", 64'(bif.blk_start), 64'd0);

    // Table-driven jobs
    for (int v = 0; v < 5; v++) begin
      set_lat(vecs[v].lat, vecs[v].lat, vecs[v].lat, vecs[v].lat);
      pulse_start(vecs[v].first, vecs[v].count);
      wait_idle($sformatf("job%0d", v));
      check($sformatf("job%0d_total", v), total, vecs[v].exp_total);
      check($sformatf("job%0d_regions_done", v), 64'(regions_done), 64'(vecs[v].exp_rd));
      check($sformatf("job%0d_done_pulses", v), 64'(done_cnt), 64'd1);
      check($sformatf("job%0d_busy_low", v), 64'(busy), 64'd0);
      check($sformatf("job%0d_start_low", v), 64'(bif.blk_start), 64'd0);
      check($sformatf("job%0d_issues", v), 64'(issue_log.size()), 64'(vecs[v].count));
      for (int k = 0; k < issue_log.size(); k++) begin
        exp_r = vecs[v].first + 16'(k);
        check($sformatf("job%0d_region%0d", v, k), 64'(issue_log[k]), 64'(exp_r));
      end
    end

    // All four lanes raise valid on the same cycle: grants go out on consecutive cycles.
    set_lat(13, 12, 11, 10);
    pulse_start(16'd40, 17'd4);
    wait_idle("samecyc");
    check("samecyc_total", total, 64'd502);
    check("samecyc_acc_count", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("samecyc_grant%0d_cycle", k), 64'(acc_cyc[k] - acc_cyc[0]), 64'(k));
        check($sformatf("samecyc_grant%0d_value", k), acc_delta[k], 64'(3 * (40 + k) + 1));
      end
    end

    // Abort with lane0 in HOLD and lanes 1,2 still running.
    begin
      bit seen = 1'b0;
      set_lat(5, 60, 60, 60);
      pulse_start(16'd20, 17'd3);
      for (int n = 0; n < 200; n++) begin
        if (bif.blk_valid[0]) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      check("abort_valid_seen", 64'(seen), 64'd1);
      step();
      check("abort_lanes_running", 64'(bif.blk_start), 64'h7);
      abort = 1'b1;
      step();
      check("abort_start_dropped", 64'(bif.blk_start), 64'd0);
      wait_idle("abort");
      abort = 1'b0;
      check("abort_total", total, 64'd61);
      check("abort_regions_done", 64'(regions_done), 64'd1);
      check("abort_done_pulses", 64'(done_cnt), 64'd1);
      check("abort_issues", 64'(issue_log.size()), 64'd3);
    end

    // Empty job: one busy cycle, done two cycles after start, second start ignored.
    set_lat(10, 10, 10, 10);
    step();
    clear_logs();
    region_first = 16'd9;
    region_count = 17'd0;
    start = 1'b1;
    step();
    check("empty_busy_c1", 64'(busy), 64'd1);
    check("empty_done_c1", 64'(done), 64'd0);
    region_count = 17'd5;
    step();
    start = 1'b0;
    check("empty_busy_c2", 64'(busy), 64'd0);
    check("empty_done_c2", 64'(done), 64'd1);
    repeat (20) step();
    check("empty_busy_after", 64'(busy), 64'd0);
    check("empty_done_pulses", 64'(done_cnt), 64'd1);
    check("empty_no_blk_start", 64'(start_seen), 64'd0);

    // Reset held two cycles in the middle of a run.
    begin
      bit got = 1'b0;
      pulse_start(16'd0, 17'd10);
      for (int n = 0; n < 500; n++) begin
        if (regions_done >= 17'd2) begin
          got = 1'b1;
          break;
        end
        step();
      end
      check("midrst_progress", 64'(got), 64'd1);
      rst = 1'b1;
      step();
      check("midrst_blk_start", 64'(bif.blk_start), 64'd0);
      check("midrst_total", total, 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      step();
      rst = 1'b0;
      repeat (3) step();
      check("midrst_stays_idle", 64'({busy, bif.blk_start}), 64'd0);
      check("midrst_regions_done", 64'(regions_done), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
